// File: rtl/lcounter_inv_seq.sv
// lcounter_inv_seq: Spongent 8-bit round-counter generator that steps the LFSR backwards.
// Optional LCOUNTER_BIDIR_EN adds a dir_i port that selects forward stepping for a whole run.
//
// state | meaning
// IDLE  | waiting for start_i; outputs not valid
// RUN   | presenting one counter value per accepted handshake
module lcounter_inv_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  seed_i,
    input  logic [7:0]  rounds_i,
    input  logic        out_ready_i,
`ifdef LCOUNTER_BIDIR_EN
    input  logic        dir_i,
`endif
    output logic        busy_o,
    output logic        out_valid_o,
    output logic [15:0] lc_o,
    output logic [15:0] lc_rev_o,
    output logic [7:0]  final_state_o,
    output logic        done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    fsm_e       fsm_q, fsm_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] final_q, final_d;
    logic       done_q, done_d;
    logic [7:0] step_nxt;

    function automatic logic [7:0] inv_step(input logic [7:0] c);
        return {c[0] ^ c[4] ^ c[3] ^ c[2], c[7:1]};
    endfunction

`ifdef LCOUNTER_BIDIR_EN
    logic dir_q, dir_d;

    function automatic logic [7:0] fwd_step(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[3] ^ c[2] ^ c[1]};
    endfunction

    assign step_nxt = dir_q ? fwd_step(lfsr_q) : inv_step(lfsr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) dir_q <= 1'b0;
        else       dir_q <= dir_d;
    end
`else
    assign step_nxt = inv_step(lfsr_q);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            lfsr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            final_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            final_q <= final_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        final_d = final_q;
        done_d  = 1'b0;
`ifdef LCOUNTER_BIDIR_EN
        dir_d   = dir_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    if (rounds_i != 8'h00) begin
                        lfsr_d = seed_i;
                        cnt_d  = rounds_i;
`ifdef LCOUNTER_BIDIR_EN
                        dir_d  = dir_i;
`endif
                        fsm_d  = RUN;
                    end else begin
                        final_d = seed_i;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready_i) begin
                    lfsr_d = step_nxt;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        fsm_d   = IDLE;
                        final_d = step_nxt;
                        done_d  = 1'b1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign out_valid_o   = (fsm_q == RUN);
    assign busy_o        = (fsm_q == RUN);
    assign lc_o          = {8'h00, lfsr_q};
    assign final_state_o = final_q;
    assign done_o        = done_q;

    // Pure wiring: state bit i lands on lc_rev bit 15-i.
    always_comb begin
        lc_rev_o = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            lc_rev_o[15-i] = lfsr_q[i];
        end
    end

endmodule

// File: tb/tb_lcounter_inv_seq.sv
// Self-checking bench for lcounter_inv_seq: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_lcounter_inv_seq;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [7:0]  seed, rounds;
    logic        busy, out_valid, done;
    logic [15:0] lc, lc_rev;
    logic [7:0]  final_state;
`ifdef LCOUNTER_BIDIR_EN
    logic        dir;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcounter_inv_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .seed_i        (seed),
        .rounds_i      (rounds),
        .out_ready_i   (out_ready),
`ifdef LCOUNTER_BIDIR_EN
        .dir_i         (dir),
`endif
        .busy_o        (busy),
        .out_valid_o   (out_valid),
        .lc_o          (lc),
        .lc_rev_o      (lc_rev),
        .final_state_o (final_state),
        .done_o        (done)
    );

    // Forward Spongent step: shift left, feedback is parity of bits 7,3,2,1.
    function automatic logic [7:0] fwd_m(input logic [7:0] v);
        return {v[6:0], ^(v & 8'h8E)};
    endfunction

    // Inverse by definition: the unique predecessor whose forward step gives v.
    function automatic logic [7:0] inv_m(input logic [7:0] v);
        for (int p = 0; p < 256; p++) begin
            if (fwd_m(8'(p)) == v) return 8'(p);
        end
        return 8'h00;
    endfunction

    function automatic logic [15:0] rev_m(input logic [7:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = r | (16'h8000 >> i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue holds the values still to be emitted plus the final state.
    bit         m_run  = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_lc    = 8'h00;
    logic [7:0] m_final = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] log_q[$];

    initial begin
        logic [7:0] last_lc;
        bit         last_v;
        bit         dirf;
        logic [7:0] v;
        last_lc = 8'h00;
        last_v  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && last_v && out_ready) log_q.push_back(last_lc);
`ifdef LCOUNTER_BIDIR_EN
            dirf = dir;
`else
            dirf = 1'b0;
`endif
            m_done = 1'b0;
            if (rst) begin
                m_run = 1'b0;
                m_q.delete();
                m_lc = 8'h00;
                m_final = 8'h00;
            end else if (m_run) begin
                if (out_ready) begin
                    void'(m_q.pop_front());
                    m_lc = m_q[0];
                    if (m_q.size() == 1) begin
                        m_run = 1'b0;
                        m_final = m_q[0];
                        m_done = 1'b1;
                        m_q.delete();
                    end
                end
            end else if (start) begin
                if (rounds != 8'h00) begin
                    m_q.delete();
                    v = seed;
                    m_q.push_back(v);
                    for (int i = 0; i < int'(rounds); i++) begin
                        v = dirf ? fwd_m(v) : inv_m(v);
                        m_q.push_back(v);
                    end
                    m_run = 1'b1;
                    m_lc = seed;
                end else begin
                    m_final = seed;
                    m_done = 1'b1;
                end
            end
            chk("busy", busy, m_run);
            chk("out_valid", out_valid, m_run);
            chk("lc", lc, {8'h00, m_lc});
            chk("lc_rev", lc_rev, rev_m(m_lc));
            chk("final_state", final_state, m_final);
            chk("done", done, m_done);
            last_v  = out_valid;
            last_lc = lc[7:0];
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || m_run) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic kick(input logic [7:0] s, input logic [7:0] r);
        log_q.delete();
        seed   = s;
        rounds = r;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        logic [7:0] f[46];
        rst = 1'b1; start = 1'b0; seed = 8'h00; rounds = 8'h00; out_ready = 1'b0;
`ifdef LCOUNTER_BIDIR_EN
        dir = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("model_inv_2c", {8'h00, inv_m(8'h2C)}, 16'h0016);
        chk("model_fwd_05", {8'h00, fwd_m(8'h05)}, 16'h000B);
        chk("model_rev_01", rev_m(8'h01), 16'h8000);

        // Inverse run at full throughput
        out_ready = 1'b1;
        kick(8'h2C, 8'd3);
        wait_idle(20);
        chk("inv_len", 16'(log_q.size()), 16'd3);
        if (log_q.size() == 3) begin
            chk("inv_v0", {8'h00, log_q[0]}, 16'h002C);
            chk("inv_v1", {8'h00, log_q[1]}, 16'h0016);
            chk("inv_v2", {8'h00, log_q[2]}, 16'h000B);
        end
        chk("inv_final", {8'h00, final_state}, 16'h0005);

        // Backpressure on the second value
        kick(8'h2C, 8'd3);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_lc", lc, 16'h0016);
        out_ready = 1'b1;
        wait_idle(20);
        chk("bp_len", 16'(log_q.size()), 16'd3);
        if (log_q.size() == 3) begin
            chk("bp_v1", {8'h00, log_q[1]}, 16'h0016);
            chk("bp_v2", {8'h00, log_q[2]}, 16'h000B);
        end
        chk("bp_final", {8'h00, final_state}, 16'h0005);

        // Zero rounds, then lc_rev of seed 0x01
        @(negedge clk);
        kick(8'h5A, 8'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_valid", out_valid, 1'b0);
        chk("zero_final", {8'h00, final_state}, 16'h005A);
        @(negedge clk);
        out_ready = 1'b0;
        kick(8'h01, 8'd1);
        chk("rev_01", lc_rev, 16'h8000);
        out_ready = 1'b1;
        wait_idle(20);

        // Round trip against a forward reference sequence
        f[0] = 8'h05;
        for (int i = 1; i < 46; i++) f[i] = fwd_m(f[i-1]);
        kick(f[45], 8'd45);
        wait_idle(100);
        chk("rt_len", 16'(log_q.size()), 16'd45);
        if (log_q.size() == 45) begin
            for (int i = 0; i < 45; i++) chk("rt_val", {8'h00, log_q[i]}, {8'h00, f[45-i]});
        end
        chk("rt_final", {8'h00, final_state}, 16'h0005);

        // Start ignored while busy, then reset at the second value
        kick(8'h9D, 8'd10);
        seed  = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_lc", lc, 16'h0000);
        chk("rst_lc_rev", lc_rev, 16'h0000);
        chk("rst_final", {8'h00, final_state}, 16'h0000);
        chk("rst_done", done, 1'b0);
        kick(8'h2C, 8'd3);
        wait_idle(20);
        chk("post_rst_final", {8'h00, final_state}, 16'h0005);

`ifdef LCOUNTER_BIDIR_EN
        dir = 1'b1;
        kick(8'h05, 8'd3);
        dir = 1'b0;
        wait_idle(20);
        chk("fwd_len", 16'(log_q.size()), 16'd3);
        if (log_q.size() == 3) begin
            chk("fwd_v0", {8'h00, log_q[0]}, 16'h0005);
            chk("fwd_v1", {8'h00, log_q[1]}, 16'h000B);
            chk("fwd_v2", {8'h00, log_q[2]}, 16'h0016);
        end
        chk("fwd_final", {8'h00, final_state}, 16'h002C);
`endif

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 3) == 0);
            seed      = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            rounds    = 8'($urandom_range(0, 12));
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef LCOUNTER_BIDIR_EN
            dir       = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcounter_inv_seq.md
# lcounter_inv_seq

Sequential round-counter generator that runs the Spongent 8-bit round LFSR in reverse. It is loaded with a counter value, such as the forward state after the last round, and emits that value and then successive predecessor values, one per accepted handshake, for a programmed number of rounds. It sits beside the permutation datapath, which needs the round constants in reverse order when it unrolls or undoes rounds, and it also provides the bit-reversed constant used at the opposite end of the state.

## Interface
- No parameters.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only when busy=0.
- seed  input  8  counter value that is emitted first.
- rounds  input  8  number of values to emit; 0 is legal.
- out_ready  input  1  consumer accepts lc this cycle.
- dir  input  1  present only with LCOUNTER_BIDIR_EN; 1 = forward step, 0 = inverse step.
- busy  output  1  high from the start accept until the last value is accepted.
- out_valid  output  1  lc and lc_rev are valid.
- lc  output  16  current counter value, {8'h00, state}.
- lc_rev  output  16  {bitrev8(state), 8'h00}, where bit i of state maps to bit 15-i.
- final_state  output  8  state after the last step; held until the next start.
- done  output  1  one-cycle pulse when a run completes.

## Operation
- Inverse step: prev[6:0] = cur[7:1] and prev[7] = cur[0]^cur[4]^cur[3]^cur[2]. This exactly undoes the forward step next = {cur[6:0], cur[7]^cur[3]^cur[2]^cur[1]}.
- All state arithmetic is 8 bits wide. The count register is 8 bits.
- The FSM has two states, IDLE and RUN.
- IDLE, start=1, rounds!=0:
  - state ← seed, cnt ← rounds, latch dir if present.
  - Go to RUN.
- IDLE, start=1, rounds=0:
  - final_state ← seed and done=1 on the next cycle.
  - Stay in IDLE; out_valid is never asserted.
- IDLE, start=0: hold all registers.
- RUN:
  - out_valid=1, busy=1.
  - On out_valid&&out_ready: state ← step(state) and cnt ← cnt-1.
  - If cnt was 1: go to IDLE, final_state ← step(state), done=1 for one cycle.
  - Without out_ready: state, lc and cnt hold stable. No value is ever dropped or duplicated.
- start is ignored while busy=1, including on the cycle of the last accept.
- The state wraps freely through the 8-bit space. The value 0x00 is a fixed point of both steps and is emitted unchanged.
- rst in any state: return to IDLE on the next edge and drop any run in progress without a done pulse.
- Reset values: busy=0, out_valid=0, done=0, lc=0, lc_rev=0, final_state=0, and the internal cnt and state registers are 0.

## Timing
- Start accepted at edge t → busy=1 and out_valid=1 with lc={8'h00,seed} after edge t.
- Each accepted value advances the state at the next edge. At full throughput (out_ready held high) the block delivers one value per cycle.
- A run with rounds=N and no stalls keeps out_valid high for exactly N cycles. done pulses in the cycle after the last accept, with busy=0 in that same cycle.
- For a rounds=0 start, done appears one cycle after the start edge.
- The earliest next start is the cycle in which done is high; it is accepted because busy=0.
- lc, lc_rev and out_valid come directly from registers. The only logic in front of the outputs is the zero padding and the bit reversal wiring.

## Configuration
- LCOUNTER_BIDIR_EN defined:
  - The dir port exists and is latched at start.
  - dir=1 selects the forward step for the whole run; dir=0 selects the inverse step.
- LCOUNTER_BIDIR_EN undefined:
  - There is no dir port and the block always uses the inverse step.
  - Gate count is reduced accordingly.

## Test plan
- Inverse run: seed=0x2C, rounds=3, out_ready=1 → lc sequence 0x002C, 0x0016, 0x000B; final_state=0x05; done pulses one cycle after the third value.
- Backpressure: same run with out_ready low for 2 cycles on the second value → lc holds 0x0016 for those cycles; sequence and final_state unchanged.
- Zero rounds and lc_rev: start with rounds=0, seed=0x5A → no out_valid, done after 1 cycle, final_state=0x5A. Separately, seed=0x01 emits lc_rev=0x8000.
- Round trip against the forward reference: seed=0x05, rounds=45, step forward 45 times in a bench model, then run inverse from the result → final_state=0x05, and every emitted value matches the forward sequence reversed.
- Start ignored while busy, then reset mid-run: start pulse during RUN → ignored. rst at the second value → all outputs 0 next cycle, no done pulse. A new start then runs normally.
- LCOUNTER_BIDIR_EN, dir=1: seed=0x05, rounds=3 → lc sequence 0x0005, 0x000B, 0x0016; final_state=0x2C.
